// File: rtl/setreset_sequencer.sv
// setreset_sequencer: buffers one 16-bit command word per wordline from an
// AXI-Stream, then walks wl_start..wl_end-1 loading the two SR reference DAC
// codes, settling the WL switch, firing a timed SET or RESET pulse and
// discharging. All pin-facing outputs are registered.
module setreset_sequencer #(
  parameter int NUM_WL          = 256,
  parameter int AXIS_DATA_WIDTH = 16,
  parameter int PW              = 16
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       start,
  input  logic                       abort,
  input  logic [8:0]                 wl_start,
  input  logic [8:0]                 wl_end,
  input  logic [PW-1:0]              settle_cycles,
  input  logic [PW-1:0]              pulse_cycles,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                       s_axis_tvalid,
  input  logic                       s_axis_tlast,
  output logic                       s_axis_tready,
  output logic [8:0]                 ADDR,
  output logic [7:0]                 DIN,
  output logic                       CLKDAC,
  output logic                       DACWL_SW,
  output logic                       SET,
  output logic                       RESET,
  output logic                       DISCHG,
  output logic                       busy,
  output logic                       done,
  output logic [1:0]                 err
);

  localparam int AW = $clog2(NUM_WL);
  localparam logic [9:0] NUM_WL_L = 10'(NUM_WL);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_RECV    = 4'd1,
    S_LD0     = 4'd2,
    S_LD0_CLK = 4'd3,
    S_LD1     = 4'd4,
    S_LD1_CLK = 4'd5,
    S_SETTLE  = 4'd6,
    S_PULSE   = 4'd7,
    S_DISCH   = 4'd8,
    S_NEXT    = 4'd9,
    S_DONE    = 4'd10
  } state_t;

  state_t        r_state;
  logic [8:0]    r_wl_start;
  logic [8:0]    r_wl_end;
  logic [PW-1:0] r_settle;
  logic [PW-1:0] r_pulse;
  logic [PW-1:0] r_cnt;
  logic [8:0]    r_wr_ptr;
  logic [8:0]    r_cur;
  logic [9:0]    r_rx_cnt;
  logic          r_is_reset;
  logic          r_abort_pend;
  logic [NUM_WL-1:0] r_valid;
  // Buffer entry: {mode is RESET, srref0[5:0], srref1[5:0]}; validity kept in r_valid.
  logic [12:0]   r_buf [NUM_WL];

  logic          w_range_ok;
  logic          w_accept;
  logic          w_in_range;
  logic          w_wr_en;
  logic [1:0]    w_mode;
  logic          w_legal;
  logic [9:0]    w_rx_cnt_nxt;
  logic [8:0]    w_span;
  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_cur_idx;
  logic [12:0]   w_entry;
  logic          w_unused;

  assign w_range_ok   = (wl_end > wl_start) && ({1'b0, wl_end} <= NUM_WL_L);
  assign w_accept     = s_axis_tvalid && s_axis_tready;
  assign w_in_range   = (r_wr_ptr < r_wl_end);
  assign w_mode       = s_axis_tdata[15:14];
  assign w_legal      = (w_mode == 2'b01) || (w_mode == 2'b10);
  assign w_rx_cnt_nxt = (r_rx_cnt == 10'h3FF) ? r_rx_cnt : (r_rx_cnt + 10'd1);
  assign w_span       = r_wl_end - r_wl_start;
  assign w_wr_idx     = r_wr_ptr[AW-1:0];
  assign w_cur_idx    = r_cur[AW-1:0];
  assign w_entry      = r_buf[w_cur_idx];
  assign w_wr_en      = (r_state == S_RECV) && !abort && w_accept && w_in_range;
  assign w_unused     = ^{s_axis_tdata[7:6]};

  // Command buffer storage; contents need no reset because r_valid gates use.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_buf[w_wr_idx] <= {w_mode[1], s_axis_tdata[13:8], s_axis_tdata[5:0]};
    end
  end

  // Sequencer FSM with registered pin outputs; strobes default low each cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= S_IDLE;
      r_wl_start    <= 9'd0;
      r_wl_end      <= 9'd0;
      r_settle      <= '0;
      r_pulse       <= '0;
      r_cnt         <= '0;
      r_wr_ptr      <= 9'd0;
      r_cur         <= 9'd0;
      r_rx_cnt      <= 10'd0;
      r_is_reset    <= 1'b0;
      r_abort_pend  <= 1'b0;
      r_valid       <= '0;
      s_axis_tready <= 1'b0;
      ADDR          <= 9'd0;
      DIN           <= 8'd0;
      CLKDAC        <= 1'b0;
      DACWL_SW      <= 1'b0;
      SET           <= 1'b0;
      RESET         <= 1'b0;
      DISCHG        <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 2'b00;
    end else begin
      CLKDAC   <= 1'b0;
      DACWL_SW <= 1'b0;
      SET      <= 1'b0;
      RESET    <= 1'b0;
      DISCHG   <= 1'b0;
      done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_range_ok) begin
              r_wl_start    <= wl_start;
              r_wl_end      <= wl_end;
              r_settle      <= settle_cycles;
              r_pulse       <= (pulse_cycles == '0) ? PW'(1) : pulse_cycles;
              r_wr_ptr      <= wl_start;
              r_rx_cnt      <= 10'd0;
              r_abort_pend  <= 1'b0;
              r_valid       <= '0;
              err           <= 2'b00;
              busy          <= 1'b1;
              s_axis_tready <= 1'b1;
              r_state       <= S_RECV;
            end else begin
              err[1] <= 1'b1;
              done   <= 1'b1;
            end
          end
        end
        S_RECV: begin
          if (abort) begin
            s_axis_tready <= 1'b0;
            done          <= 1'b1;
            r_state       <= S_DONE;
          end else if (w_accept) begin
            if (w_in_range) begin
              r_valid[w_wr_idx] <= w_legal;
              r_wr_ptr          <= r_wr_ptr + 9'd1;
            end
            if (w_mode == 2'b11) begin
              err[0] <= 1'b1;
            end
            r_rx_cnt <= w_rx_cnt_nxt;
            if (s_axis_tlast) begin
              if (w_rx_cnt_nxt != {1'b0, w_span}) begin
                err[1] <= 1'b1;
              end
              s_axis_tready <= 1'b0;
              r_cur         <= r_wl_start;
              r_state       <= S_NEXT;
            end
          end
        end
        S_NEXT: begin
          if (abort || (r_cur >= r_wl_end)) begin
            done    <= 1'b1;
            r_state <= S_DONE;
          end else if (!r_valid[w_cur_idx]) begin
            r_cur <= r_cur + 9'd1;
          end else begin
            ADDR       <= {1'b0, r_cur[7:0]};
            DIN        <= {2'b00, w_entry[11:6]};
            r_is_reset <= w_entry[12];
            r_state    <= S_LD0;
          end
        end
        S_LD0: begin
          if (abort) begin
            DISCHG <= 1'b1; r_abort_pend <= 1'b1; r_state <= S_DISCH;
          end else begin
            CLKDAC  <= 1'b1;
            r_state <= S_LD0_CLK;
          end
        end
        S_LD0_CLK: begin
          if (abort) begin
            DISCHG <= 1'b1; r_abort_pend <= 1'b1; r_state <= S_DISCH;
          end else begin
            ADDR    <= {1'b1, r_cur[7:0]};
            DIN     <= {2'b00, w_entry[5:0]};
            r_state <= S_LD1;
          end
        end
        S_LD1: begin
          if (abort) begin
            DISCHG <= 1'b1; r_abort_pend <= 1'b1; r_state <= S_DISCH;
          end else begin
            CLKDAC  <= 1'b1;
            r_state <= S_LD1_CLK;
          end
        end
        S_LD1_CLK: begin
          if (abort) begin
            DISCHG <= 1'b1; r_abort_pend <= 1'b1; r_state <= S_DISCH;
          end else if (r_settle != '0) begin
            DACWL_SW <= 1'b1;
            r_cnt    <= r_settle;
            r_state  <= S_SETTLE;
          end else begin
            DACWL_SW <= 1'b1;
            SET      <= !r_is_reset;
            RESET    <= r_is_reset;
            r_cnt    <= r_pulse;
            r_state  <= S_PULSE;
          end
        end
        S_SETTLE: begin
          if (abort) begin
            DISCHG <= 1'b1; r_abort_pend <= 1'b1; r_state <= S_DISCH;
          end else if (r_cnt == PW'(1)) begin
            DACWL_SW <= 1'b1;
            SET      <= !r_is_reset;
            RESET    <= r_is_reset;
            r_cnt    <= r_pulse;
            r_state  <= S_PULSE;
          end else begin
            DACWL_SW <= 1'b1;
            r_cnt    <= r_cnt - PW'(1);
          end
        end
        S_PULSE: begin
          if (abort) begin
            DISCHG <= 1'b1; r_abort_pend <= 1'b1; r_state <= S_DISCH;
          end else if (r_cnt == PW'(1)) begin
            DISCHG  <= 1'b1;
            r_state <= S_DISCH;
          end else begin
            DACWL_SW <= 1'b1;
            SET      <= !r_is_reset;
            RESET    <= r_is_reset;
            r_cnt    <= r_cnt - PW'(1);
          end
        end
        S_DISCH: begin
          if (r_abort_pend) begin
            r_abort_pend <= 1'b0;
            done         <= 1'b1;
            r_state      <= S_DONE;
          end else begin
            r_cur   <= r_cur + 9'd1;
            r_state <= S_NEXT;
          end
        end
        S_DONE: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          s_axis_tready <= 1'b0;
          busy          <= 1'b0;
          r_state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_setreset_sequencer.sv
// Directed bench for setreset_sequencer: hand-computed latencies, strobe
// sequences and pulse counts for the main scenarios, abort, reset and range errors.
module tb_setreset_sequencer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [8:0]  wl_start = 9'd0;
  logic [8:0]  wl_end = 9'd0;
  logic [15:0] settle_cycles = 16'd0;
  logic [15:0] pulse_cycles = 16'd0;
  logic [15:0] s_axis_tdata = 16'd0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tready;
  logic [8:0]  ADDR;
  logic [7:0]  DIN;
  logic        CLKDAC, DACWL_SW, SET, RESET, DISCHG, busy, done;
  logic [1:0]  err;

  setreset_sequencer #(.NUM_WL(256), .AXIS_DATA_WIDTH(16), .PW(16)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .wl_start(wl_start), .wl_end(wl_end),
    .settle_cycles(settle_cycles), .pulse_cycles(pulse_cycles),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .ADDR(ADDR), .DIN(DIN), .CLKDAC(CLKDAC), .DACWL_SW(DACWL_SW),
    .SET(SET), .RESET(RESET), .DISCHG(DISCHG),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miss = 0;

  // Pin activity recorder, sampled on the falling edge
  int m_strobes = 0, m_set_cyc = 0, m_rst_cyc = 0, m_set_pulses = 0;
  int m_rst_pulses = 0, m_dischg = 0, m_bad = 0;
  logic [8:0] m_addr [2048];
  logic [7:0] m_din  [2048];
  logic prev_set = 1'b0, prev_rst = 1'b0;

  always @(negedge clk) begin
    if (rstn) begin
      if (CLKDAC) begin
        if (m_strobes < 2048) begin
          m_addr[m_strobes] = ADDR;
          m_din[m_strobes]  = DIN;
        end
        m_strobes++;
      end
      if (SET) m_set_cyc++;
      if (RESET) m_rst_cyc++;
      if (SET && !prev_set) m_set_pulses++;
      if (RESET && !prev_rst) m_rst_pulses++;
      if (DISCHG) m_dischg++;
      if ((SET && RESET) || ((SET || RESET) && !DACWL_SW)) m_bad++;
    end
    prev_set = SET;
    prev_rst = RESET;
  end

  int b_str, b_set, b_rst, b_sp, b_rp, b_dis, b_bad;
  int lat;

  task automatic chk_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic snap();
    b_str = m_strobes; b_set = m_set_cyc; b_rst = m_rst_cyc;
    b_sp = m_set_pulses; b_rp = m_rst_pulses; b_dis = m_dischg; b_bad = m_bad;
  endtask

  task automatic run_start(input logic [8:0] ws, input logic [8:0] we,
                           input logic [15:0] st, input logic [15:0] pc);
    @(negedge clk);
    wl_start = ws; wl_end = we; settle_cycles = st; pulse_cycles = pc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [15:0] d, input logic last);
    int t;
    s_axis_tdata = d; s_axis_tvalid = 1'b1; s_axis_tlast = last;
    t = 0;
    while (!s_axis_tready && t < 100) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic wait_set();
    int t;
    t = 0;
    while (!SET && t < 200) begin
      @(negedge clk);
      t++;
    end
  endtask

  initial begin
    // Reset state
    #1;
    chk_vec("rst_tready", 32'(s_axis_tready), 32'd0);
    chk_vec("rst_busy", 32'(busy), 32'd0);
    chk_vec("rst_pins", 32'({CLKDAC, DACWL_SW, SET, RESET, DISCHG, done}), 32'd0);
    chk_vec("rst_err", 32'(err), 32'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    // Out-of-range end: error, done pulse, no stream
    run_start(9'd0, 9'd300, 16'd1, 16'd1);
    chk_vec("big_end_done", 32'(done), 32'd1);
    chk_vec("big_end_err", 32'(err), 32'd2);
    chk_vec("big_end_tready", 32'(s_axis_tready), 32'd0);
    @(negedge clk);

    // T1: 4 SET wordlines, settle 8, pulse 20 -> 34 cycles per WL
    snap();
    run_start(9'd0, 9'd4, 16'd8, 16'd20);
    chk_vec("t1_busy", 32'(busy), 32'd1);
    chk_vec("t1_err_clr", 32'(err), 32'd0);
    for (int i = 0; i < 4; i++) send(16'h7E2A, i == 3);
    chk_vec("t1_tready_drop", 32'(s_axis_tready), 32'd0);
    wait_done(lat);
    #1;
    chk_vec("t1_latency", 32'(lat), 32'd137);
    chk_vec("t1_set_cyc", 32'(m_set_cyc - b_set), 32'd80);
    chk_vec("t1_set_pulses", 32'(m_set_pulses - b_sp), 32'd4);
    chk_vec("t1_rst_cyc", 32'(m_rst_cyc - b_rst), 32'd0);
    chk_vec("t1_dischg", 32'(m_dischg - b_dis), 32'd4);
    chk_vec("t1_strobes", 32'(m_strobes - b_str), 32'd8);
    chk_vec("t1_bad", 32'(m_bad - b_bad), 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk_vec("t1_addr0", 32'(m_addr[b_str + 2*k]), 32'(k));
      chk_vec("t1_din0", 32'(m_din[b_str + 2*k]), 32'h3E);
      chk_vec("t1_addr1", 32'(m_addr[b_str + 2*k + 1]), 32'(256 + k));
      chk_vec("t1_din1", 32'(m_din[b_str + 2*k + 1]), 32'h2A);
    end
    chk_vec("t1_err", 32'(err), 32'd0);
    chk_vec("t1_busy_done", 32'(busy), 32'd1);
    @(negedge clk);
    chk_vec("t1_busy_after", 32'(busy), 32'd0);

    // T2: RESET on WL0/WL2, skip WL1; settle 2, pulse 3 -> 11+1+11+1
    snap();
    run_start(9'd0, 9'd3, 16'd2, 16'd3);
    send(16'h8101, 1'b0);
    send(16'h0000, 1'b0);
    send(16'h8101, 1'b1);
    wait_done(lat);
    #1;
    chk_vec("t2_latency", 32'(lat), 32'd24);
    chk_vec("t2_rst_cyc", 32'(m_rst_cyc - b_rst), 32'd6);
    chk_vec("t2_rst_pulses", 32'(m_rst_pulses - b_rp), 32'd2);
    chk_vec("t2_set_cyc", 32'(m_set_cyc - b_set), 32'd0);
    chk_vec("t2_strobes", 32'(m_strobes - b_str), 32'd4);
    chk_vec("t2_addr_wl0", 32'(m_addr[b_str]), 32'd0);
    chk_vec("t2_addr_wl2", 32'(m_addr[b_str + 3]), 32'd258);
    chk_vec("t2_din", 32'(m_din[b_str + 1]), 32'h01);
    chk_vec("t2_bad", 32'(m_bad - b_bad), 32'd0);
    @(negedge clk);

    // T3: full 256-wordline sweep, settle 0, pulse 0 (as 1) -> 7 per WL
    snap();
    run_start(9'd0, 9'd256, 16'd0, 16'd0);
    for (int i = 0; i < 256; i++) send(16'h7E2A, i == 255);
    wait_done(lat);
    #1;
    chk_vec("t3_latency", 32'(lat), 32'd1793);
    chk_vec("t3_strobes", 32'(m_strobes - b_str), 32'd512);
    chk_vec("t3_set_cyc", 32'(m_set_cyc - b_set), 32'd256);
    begin
      int bad;
      bad = 0;
      for (int k = 0; k < 256; k++) begin
        if (m_addr[b_str + 2*k] !== 9'(k) || m_addr[b_str + 2*k + 1] !== 9'(256 + k)) bad++;
      end
      chk_vec("t3_addr_sweep", 32'(bad), 32'd0);
    end
    chk_vec("t3_err", 32'(err), 32'd0);
    @(negedge clk);
    chk_vec("t3_busy_after", 32'(busy), 32'd0);

    // T4a: 3 words for 4 WLs -> count error, WL3 skipped
    snap();
    run_start(9'd0, 9'd4, 16'd1, 16'd1);
    for (int i = 0; i < 3; i++) send(16'h7E2A, i == 2);
    wait_done(lat);
    #1;
    chk_vec("t4a_latency", 32'(lat), 32'd26);
    chk_vec("t4a_err", 32'(err), 32'd2);
    chk_vec("t4a_strobes", 32'(m_strobes - b_str), 32'd6);
    chk_vec("t4a_set_pulses", 32'(m_set_pulses - b_sp), 32'd3);
    @(negedge clk);

    // T4b: illegal mode word on WL0 stored as skip
    snap();
    run_start(9'd0, 9'd2, 16'd1, 16'd1);
    send(16'hC000, 1'b0);
    send(16'h7E2A, 1'b1);
    wait_done(lat);
    #1;
    chk_vec("t4b_latency", 32'(lat), 32'd10);
    chk_vec("t4b_err", 32'(err), 32'd1);
    chk_vec("t4b_strobes", 32'(m_strobes - b_str), 32'd2);
    chk_vec("t4b_addr", 32'(m_addr[b_str]), 32'd1);
    @(negedge clk);

    // T5: abort at pulse cycle 5 of 20
    snap();
    run_start(9'd0, 9'd1, 16'd0, 16'd20);
    send(16'h7E2A, 1'b1);
    wait_set();
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk_vec("t5_set_drop", 32'(SET), 32'd0);
    chk_vec("t5_dischg", 32'(DISCHG), 32'd1);
    chk_vec("t5_sw_drop", 32'(DACWL_SW), 32'd0);
    @(negedge clk);
    chk_vec("t5_done", 32'(done), 32'd1);
    chk_vec("t5_dischg_once", 32'(DISCHG), 32'd0);
    repeat (5) @(negedge clk);
    #1;
    chk_vec("t5_set_cyc", 32'(m_set_cyc - b_set), 32'd5);
    chk_vec("t5_strobes", 32'(m_strobes - b_str), 32'd2);
    chk_vec("t5_dischg_cnt", 32'(m_dischg - b_dis), 32'd1);
    chk_vec("t5_busy", 32'(busy), 32'd0);

    // Async reset mid-pulse
    run_start(9'd0, 9'd1, 16'd0, 16'd20);
    send(16'h7E2A, 1'b1);
    wait_set();
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk_vec("arst_pins", 32'({CLKDAC, DACWL_SW, SET, RESET, DISCHG, done}), 32'd0);
    chk_vec("arst_busy", 32'(busy), 32'd0);
    chk_vec("arst_addr", 32'(ADDR), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // T6: empty range -> error, done, tready never high
    run_start(9'd5, 9'd5, 16'd1, 16'd1);
    chk_vec("t6_done", 32'(done), 32'd1);
    chk_vec("t6_err", 32'(err), 32'd2);
    chk_vec("t6_tready", 32'(s_axis_tready), 32'd0);
    @(negedge clk);
    chk_vec("t6_done_once", 32'(done), 32'd0);
    chk_vec("t6_tready2", 32'(s_axis_tready), 32'd0);
    chk_vec("t6_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
